// File: rtl/serial_subtractor4.sv
// serial_subtractor4: bit-serial two's-complement subtractor, Diff = Ain - Bin - Brin.
// One full-subtractor cell is reused WIDTH times, LSB first, with the borrow
// carried between bits in a single flip-flop. Start/done handshake.

// Single full-subtractor cell: d = a - b - bi, bo = borrow out.
module serial_subtractor4_fs (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);
  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~(a ^ b) & bi);
endmodule

module serial_subtractor4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] Ain,
  input  logic [WIDTH-1:0] Bin,
  input  logic             Brin,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             ready,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sr, b_sr, r_sr;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             d, bo;
  logic             last;

  serial_subtractor4_fs u_fs (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .bi (br),
    .d  (d),
    .bo (bo)
  );

  // Counter holds the index of the bit being processed; it stops at WIDTH-1.
  assign last = (cnt == CW'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic: DONE always falls back to IDLE, so start is ignored there.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (last)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: load operands on accept, shift one bit per cycle, publish on the last bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sr <= '0;
      b_sr <= '0;
      r_sr <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      Diff <= '0;
      Bout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr <= Ain;
            b_sr <= Bin;
            br   <= Brin;
            cnt  <= '0;
          end
        end
        SHIFT: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          r_sr <= {d, r_sr[WIDTH-1:1]};
          br   <= bo;
          if (last) begin
            // Diff/Bout only move here, so they hold steady through SHIFT.
            Diff <= {d, r_sr[WIDTH-1:1]};
            Bout <= bo;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Handshake outputs decode straight from the state register.
  assign ready = (state == IDLE);
  assign busy  = (state == SHIFT);
  assign done  = (state == DONE);

endmodule

// File: doc/serial_subtractor4.md
Name: serial_subtractor4

Overview:
Bit-serial, multi-cycle two's-complement subtractor. It is the inverse-direction companion to the team's ripple-carry 4-bit adder and uses the same Ain/Bin operand convention.
- Processes one bit per clock, LSB first, through a single borrow flip-flop.
- Trades latency for area: one full-subtractor cell is reused WIDTH times.
- Used where a datapath needs A - B with a start/done handshake instead of a combinational chain.

Parameters:
WIDTH, 4, operand/result width in bits (legal range 2..16).

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous, active-high reset.
start  input  1  request; sampled only when ready=1.
Ain  input  WIDTH  minuend; sampled on the accepted start edge.
Bin  input  WIDTH  subtrahend; sampled on the accepted start edge.
Brin  input  1  borrow-in; sampled on the accepted start edge.
Diff  output  WIDTH  registered result, (Ain - Bin - Brin) mod 2^WIDTH.
Bout  output  1  registered borrow-out; 1 iff Ain < Bin + Brin (unsigned).
ready  output  1  high in IDLE only.
busy  output  1  high in SHIFT only.
done  output  1  single-cycle pulse, high in DONE only.

Behaviour:
Interface:
- One clock; reset is synchronous and active-high (ports clk and reset).
- Reset is sampled on the rising edge of clk.
- While reset=1 at the edge: state goes to IDLE; Diff=0, Bout=0, done=0, busy=0, ready=1; internal shift registers, counter and borrow flip-flop are cleared.
- Reset overrides start.

States: IDLE, SHIFT, DONE. All outputs are registered or decoded directly from state.

IDLE:
- ready=1.
- start=1 at an edge: load A shift register <= Ain, B shift register <= Bin, borrow flip-flop <= Brin, bit counter <= 0; next state SHIFT.
- start=0: stay in IDLE.

SHIFT, one bit per edge:
- a = A[0], b = B[0], br = borrow flip-flop.
- d = a ^ b ^ br.
- borrow flip-flop <= (~a & b) | (~(a ^ b) & br).
- d shifts into the MSB of the internal result register; A and B shift right.
- Counter increments. On the edge where the counter reaches WIDTH-1 (the WIDTH-th bit), next state is DONE.
- On that same edge, Diff <= completed result and Bout <= final borrow.

DONE:
- done=1 for exactly one cycle, then unconditionally IDLE.
- start is ignored in DONE (ready=0).

Latency and throughput:
- Start accepted at edge 0 → done high during the cycle after edge WIDTH.
- Minimum issue interval is WIDTH+2 cycles; back-to-back holding start=1 restarts on the first IDLE cycle.

Hold and ignore rules:
- Diff/Bout hold their values from DONE until the next DONE or reset. They do not change during SHIFT.
- start, Ain, Bin and Brin are ignored while busy or done. Operand changes after acceptance have no effect.

Boundaries:
- Reset mid-SHIFT aborts with no done pulse; Diff/Bout read 0.
- Wrap-around: 0 - 0 - 1 = all-ones with Bout=1.
- Equal operands with Brin=0 give 0 with Bout=0.
- The counter never exceeds WIDTH-1.

Test Plan:
1. WIDTH=4, Ain=9, Bin=3, Brin=0, start pulse → done in the cycle after edge 4; Diff=6, Bout=0; ready returns one cycle later.
2. Ain=3, Bin=9, Brin=0 → Diff=10 (0xA), Bout=1. Then Ain=0, Bin=0, Brin=1 → Diff=15, Bout=1.
3. Ain=15, Bin=15, Brin=1 → Diff=15, Bout=1. Then Ain=15, Bin=0, Brin=0 → Diff=15, Bout=0. Diff must hold prior value throughout SHIFT.
4. Start 9-3; pulse start with Ain=1, Bin=1 while busy → ignored, result still 6, exactly one done pulse.
5. Start 9-3; assert reset for one cycle at the second SHIFT edge → Diff=0, Bout=0, no done, ready=1. A following 7-2 gives Diff=5, Bout=0.
6. start held high; exhaustive 16×16×2 operand sweep → every result matches the reference model. done pulses are spaced exactly 6 cycles apart and each is one cycle wide.
